g4_table_updater: RTL and testbench

Update engine that writes rule entries into one G4 rule-table RAM (171-bit entries, 1-cycle registered read, synchronous write). It accepts insert/delete requests over a valid/ready handshake and scans the table through its single address port. It finds free slots, detects duplicates, and locates victims, then writes the entry and returns a one-cycle status pulse. One instance drives each G4 table (one per subset/table pair) and owns that table's `we`/`addr`/`din` port exclusively.

---
 rtl/g4_pkg.sv | 62 ++++++
 rtl/g4_table_updater_if.sv | 23 ++
 rtl/g4_entry_fmt.sv | 40 ++++
 rtl/g4_table_updater.sv | 177 +++++++++++++++++
 tb/tb_g4_table_updater.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/g4_pkg.sv
// Shared definitions for the G4 rule-table update engine: entry field layout,
// empty-slot marker, request/status encodings and engine state.
package g4_pkg;

    localparam int unsigned G4_DATA_W = 171;
    localparam int unsigned G4_ADDR_W = 11;

    localparam int unsigned SRC_IP_MSB    = 170;
    localparam int unsigned SRC_IP_LSB    = 139;
    localparam int unsigned SRC_LEN_MSB   = 138;
    localparam int unsigned SRC_LEN_LSB   = 133;
    localparam int unsigned DST_IP_MSB    = 132;
    localparam int unsigned DST_IP_LSB    = 101;
    localparam int unsigned DST_LEN_MSB   = 100;
    localparam int unsigned DST_LEN_LSB   = 95;
    localparam int unsigned SPORT_HI_MSB  = 94;
    localparam int unsigned SPORT_HI_LSB  = 79;
    localparam int unsigned SPORT_LO_MSB  = 78;
    localparam int unsigned SPORT_LO_LSB  = 63;
    localparam int unsigned DPORT_HI_MSB  = 62;
    localparam int unsigned DPORT_HI_LSB  = 47;
    localparam int unsigned DPORT_LO_MSB  = 46;
    localparam int unsigned DPORT_LO_LSB  = 31;
    localparam int unsigned PROTO_MSB     = 30;
    localparam int unsigned PROTO_LSB     = 23;
    localparam int unsigned WILDCARD_BIT  = 22;
    localparam int unsigned RULE_ID_MSB   = 21;
    localparam int unsigned RULE_ID_LSB   = 11;
    localparam int unsigned INDEX_MSB     = 10;
    localparam int unsigned INDEX_LSB     = 0;

    localparam int unsigned ID_W    = RULE_ID_MSB - RULE_ID_LSB + 1;
    localparam int unsigned INDEX_W = INDEX_MSB - INDEX_LSB + 1;

    localparam logic [ID_W-1:0] EMPTY_ID = 11'h7FF;

    typedef enum logic {
        OpInsert = 1'b0,
        OpDelete = 1'b1
    } g4_op_e;

    typedef enum logic [2:0] {
        StatOk       = 3'd0,
        StatFull     = 3'd1,
        StatNotFound = 3'd2,
        StatDup      = 3'd3,
        StatBadId    = 3'd4
    } g4_status_e;

    typedef enum logic [2:0] {
        StIdle,
        StRd,
        StCmp,
        StWr,
        StResp
    } g4_state_e;

    function automatic logic is_empty_id(input logic [ID_W-1:0] id);
        return id == EMPTY_ID;
    endfunction

endpackage

// File: rtl/g4_table_updater_if.sv
// Request/response handshake between a table-update client and the update engine.
interface g4_table_updater_if #(
    parameter int unsigned DATA_W = g4_pkg::G4_DATA_W,
    parameter int unsigned ADDR_W = g4_pkg::G4_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_op;
    logic [DATA_W-1:0] req_rule;
    logic              resp_valid;
    logic [2:0]        resp_status;
    logic [ADDR_W-1:0] resp_addr;

    modport master (
        output req_valid, req_op, req_rule,
        input  req_ready, resp_valid, resp_status, resp_addr
    );

    modport slave (
        input  req_valid, req_op, req_rule,
        output req_ready, resp_valid, resp_status, resp_addr
    );
endinterface

// File: rtl/g4_entry_fmt.sv
// Combinational entry helper: ruleID extraction, empty-slot test and write-word
// construction (index substitution or empty-entry pattern).
module g4_entry_fmt
    import g4_pkg::*;
#(
    parameter int unsigned DATA_W = G4_DATA_W,
    parameter int unsigned ADDR_W = G4_ADDR_W
) (
    input  g4_op_e            op_i,
    input  logic [DATA_W-1:0] rule_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] rd_entry_i,
    input  logic [DATA_W-1:0] new_entry_i,
    output logic [ID_W-1:0]   rule_id_o,
    output logic [ID_W-1:0]   rd_id_o,
    output logic              rd_empty_o,
    output logic              new_empty_o,
    output logic [DATA_W-1:0] wr_word_o
);

    assign rule_id_o   = rule_i[RULE_ID_MSB:RULE_ID_LSB];
    assign rd_id_o     = rd_entry_i[RULE_ID_MSB:RULE_ID_LSB];
    assign rd_empty_o  = is_empty_id(rd_id_o);
    assign new_empty_o = is_empty_id(new_entry_i[RULE_ID_MSB:RULE_ID_LSB]);

    // Only the ruleID of looked-up entries matters here.
    logic unused_bits;
    assign unused_bits = ^{rd_entry_i[DATA_W-1:RULE_ID_MSB+1], rd_entry_i[RULE_ID_LSB-1:0],
                           new_entry_i[DATA_W-1:RULE_ID_MSB+1], new_entry_i[RULE_ID_LSB-1:0]};

    always_comb begin
        wr_word_o = rule_i;
        if (op_i == OpDelete) begin
            wr_word_o = '0;
            wr_word_o[RULE_ID_MSB:RULE_ID_LSB] = EMPTY_ID;
        end
        wr_word_o[INDEX_MSB:INDEX_LSB] = wr_addr_i[INDEX_W-1:0];
    end

endmodule

// File: rtl/g4_table_updater.sv
// Insert/delete engine for one G4 rule table: scans all slots through the single
// table port, finds duplicates/free slots/victims, writes once and pulses a status.
module g4_table_updater
    import g4_pkg::*;
#(
    parameter int unsigned TABLE_ENTRY_SIZE = 29,
    parameter int unsigned ADDR_W           = G4_ADDR_W,
    parameter int unsigned DATA_W           = G4_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    g4_table_updater_if.slave bus,
    output logic [ADDR_W-1:0] tbl_addr,
    output logic              tbl_we,
    output logic [DATA_W-1:0] tbl_din,
    input  logic [DATA_W-1:0] tbl_dout
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(TABLE_ENTRY_SIZE);

    g4_state_e         state_q, state_d;
    g4_op_e            op_q, op_d;
    logic [DATA_W-1:0] rule_q, rule_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              free_vld_q, free_vld_d;
    logic [ADDR_W-1:0] free_q, free_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              resp_valid_q, resp_valid_d;
    g4_status_e        resp_status_q, resp_status_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;

    logic [ID_W-1:0]   rule_id;
    logic [ID_W-1:0]   rd_id;
    logic              rd_empty;
    logic              new_empty;
    logic [DATA_W-1:0] wr_word;

    g4_entry_fmt #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_fmt (
        .op_i        (op_q),
        .rule_i      (rule_q),
        .wr_addr_i   (wr_addr_q),
        .rd_entry_i  (tbl_dout),
        .new_entry_i (bus.req_rule),
        .rule_id_o   (rule_id),
        .rd_id_o     (rd_id),
        .rd_empty_o  (rd_empty),
        .new_empty_o (new_empty),
        .wr_word_o   (wr_word)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        rule_d        = rule_q;
        ptr_d         = ptr_q;
        free_vld_d    = free_vld_q;
        free_d        = free_q;
        wr_addr_d     = wr_addr_q;
        resp_valid_d  = 1'b0;
        resp_status_d = resp_status_q;
        resp_addr_d   = resp_addr_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    op_d       = g4_op_e'(bus.req_op);
                    rule_d     = bus.req_rule;
                    ptr_d      = '0;
                    free_vld_d = 1'b0;
                    free_d     = '0;
                    wr_addr_d  = '0;
                    if (new_empty) begin
                        state_d       = StResp;
                        resp_valid_d  = 1'b1;
                        resp_status_d = StatBadId;
                        resp_addr_d   = '0;
                    end else begin
                        state_d = StRd;
                    end
                end
            end
            StRd: state_d = StCmp;
            StCmp: begin
                if (rd_id == rule_id) begin
                    if (op_q == OpDelete) begin
                        wr_addr_d = ptr_q;
                        state_d   = StWr;
                    end else begin
                        state_d       = StResp;
                        resp_valid_d  = 1'b1;
                        resp_status_d = StatDup;
                        resp_addr_d   = ptr_q;
                    end
                end else begin
                    if (op_q == OpInsert && rd_empty && !free_vld_q) begin
                        free_vld_d = 1'b1;
                        free_d     = ptr_q;
                    end
                    // The last slot's own free-slot record counts for the final decision.
                    if (ptr_q == LastIdx) begin
                        if (op_q == OpInsert && free_vld_d) begin
                            wr_addr_d = free_d;
                            state_d   = StWr;
                        end else begin
                            state_d       = StResp;
                            resp_valid_d  = 1'b1;
                            resp_status_d = (op_q == OpInsert) ? StatFull : StatNotFound;
                            resp_addr_d   = '0;
                        end
                    end else begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = StRd;
                    end
                end
            end
            StWr: begin
                state_d       = StResp;
                resp_valid_d  = 1'b1;
                resp_status_d = StatOk;
                resp_addr_d   = wr_addr_q;
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            op_q          <= OpInsert;
            rule_q        <= '0;
            ptr_q         <= '0;
            free_vld_q    <= 1'b0;
            free_q        <= '0;
            wr_addr_q     <= '0;
            resp_valid_q  <= 1'b0;
            resp_status_q <= StatOk;
            resp_addr_q   <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            rule_q        <= rule_d;
            ptr_q         <= ptr_d;
            free_vld_q    <= free_vld_d;
            free_q        <= free_d;
            wr_addr_q     <= wr_addr_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            resp_addr_q   <= resp_addr_d;
        end
    end

    // Table port is a pure decode of registered state, so reset drops tbl_we at once.
    always_comb begin
        tbl_addr = '0;
        tbl_we   = 1'b0;
        tbl_din  = '0;
        case (state_q)
            StRd, StCmp: tbl_addr = ptr_q;
            StWr: begin
                tbl_addr = wr_addr_q;
                tbl_we   = 1'b1;
                tbl_din  = wr_word;
            end
            default: ;
        endcase
    end

    assign bus.req_ready   = rst_n && (state_q == StIdle);
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_status = resp_status_q;
    assign bus.resp_addr   = resp_addr_q;

endmodule

// File: tb/tb_g4_table_updater.sv
// Self-checking bench: behavioural table RAM plus a slot-list reference model of
// insert/delete outcomes, latencies and written words.
module tb_g4_table_updater;
    typedef logic [170:0] word_t;
    localparam int N = 30;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    g4_table_updater_if #(.DATA_W(171), .ADDR_W(11)) bus ();

    logic [10:0] tbl_addr;
    logic        tbl_we;
    word_t       tbl_din;
    word_t       tbl_dout;

    g4_table_updater #(
        .TABLE_ENTRY_SIZE (29),
        .ADDR_W           (11),
        .DATA_W           (171)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .tbl_addr (tbl_addr),
        .tbl_we   (tbl_we),
        .tbl_din  (tbl_din),
        .tbl_dout (tbl_dout)
    );

    // Table RAM with a bench-side preload port.
    word_t       mem [0:2047];
    logic        load_en;
    logic [10:0] load_addr;
    word_t       load_data;
    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (tbl_we) mem[tbl_addr] <= tbl_din;
        tbl_dout <= mem[tbl_addr];
    end

    word_t mdl [N];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic word_t mk_rule(input logic [10:0] id);
        logic [191:0] t;
        word_t w;
        for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom();
        w = t[170:0];
        w[21:11] = id;
        return w;
    endfunction

    task automatic sync_tbl();
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            load_en = 1'b1;
            load_addr = 11'(i);
            load_data = mdl[i];
        end
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic check_table(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== mdl[i]) bad++;
        check({tag, " table"}, word_t'(bad), word_t'(0));
    endtask

    task automatic do_op(input logic op, input word_t rule, input string tag);
        logic [10:0] id;
        int dup, fre, ecyc, cyc, rcyc, wcyc, nw;
        logic [2:0] est, st;
        logic [10:0] eaddr, raddr, waddr;
        logic ewr, got;
        word_t eword, wdin;

        id = rule[21:11];
        dup = -1;
        fre = -1;
        for (int i = 0; i < N; i++) begin
            if (mdl[i][21:11] == id && dup < 0) dup = i;
            if (mdl[i][21:11] == 11'h7FF && fre < 0) fre = i;
        end
        ewr = 1'b0;
        eaddr = '0;
        eword = '0;
        if (id == 11'h7FF) begin
            est = 3'd4; ecyc = 1;
        end else if (op == 1'b0) begin
            if (dup >= 0) begin
                est = 3'd3; eaddr = 11'(dup); ecyc = 2 * dup + 3;
            end else if (fre >= 0) begin
                est = 3'd0; eaddr = 11'(fre); ecyc = 2 * N + 2; ewr = 1'b1;
                eword = rule;
                eword[10:0] = 11'(fre);
            end else begin
                est = 3'd1; ecyc = 2 * N + 1;
            end
        end else begin
            if (dup >= 0) begin
                est = 3'd0; eaddr = 11'(dup); ecyc = 2 * dup + 4; ewr = 1'b1;
                eword[21:11] = 11'h7FF;
                eword[10:0] = 11'(dup);
            end else begin
                est = 3'd2; ecyc = 2 * N + 1;
            end
        end

        @(negedge clk);
        check({tag, " ready"}, word_t'(bus.req_ready), word_t'(1));
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_rule = rule;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;

        cyc = 0; got = 1'b0; nw = 0; rcyc = 0; wcyc = 0;
        st = '0; raddr = '0; waddr = '0; wdin = '0;
        while (!got && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (tbl_we) begin
                nw++; waddr = tbl_addr; wdin = tbl_din; wcyc = cyc;
            end
            if (bus.resp_valid) begin
                got = 1'b1; st = bus.resp_status; raddr = bus.resp_addr; rcyc = cyc;
            end
        end
        check({tag, " resp seen"}, word_t'(got), word_t'(1));
        check({tag, " status"}, word_t'(st), word_t'(est));
        check({tag, " resp_addr"}, word_t'(raddr), word_t'(eaddr));
        check({tag, " latency"}, word_t'(rcyc), word_t'(ecyc));
        check({tag, " writes"}, word_t'(nw), word_t'(ewr));
        if (ewr) begin
            check({tag, " wr addr"}, word_t'(waddr), word_t'(eaddr));
            check({tag, " wr data"}, wdin, eword);
            check({tag, " wr cycle"}, word_t'(wcyc), word_t'(ecyc - 1));
            mdl[eaddr] = eword;
        end
        @(negedge clk);
        check({tag, " pulse width"}, word_t'(bus.resp_valid), word_t'(0));
        check_table(tag);
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op = 1'b0;
        bus.req_rule = '0;
        load_en = 1'b0;
        load_addr = '0;
        load_data = '0;
        repeat (3) @(negedge clk);
        check("rst ready", word_t'(bus.req_ready), word_t'(0));
        check("rst resp_valid", word_t'(bus.resp_valid), word_t'(0));
        check("rst resp_status", word_t'(bus.resp_status), word_t'(0));
        check("rst resp_addr", word_t'(bus.resp_addr), word_t'(0));
        check("rst tbl_we", word_t'(tbl_we), word_t'(0));
        check("rst tbl_addr", word_t'(tbl_addr), word_t'(0));
        check("rst tbl_din", tbl_din, word_t'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("post-rst ready", word_t'(bus.req_ready), word_t'(1));

        // Slots 0-4 hold ruleIDs 1-5, the rest are empty.
        for (int i = 0; i < N; i++) mdl[i] = (i < 5) ? mk_rule(11'(i + 1)) : mk_rule(11'h7FF);
        sync_tbl();
        do_op(1'b0, mk_rule(11'd9), "ins9");
        do_op(1'b0, mk_rule(11'd3), "ins3 dup");
        do_op(1'b1, mk_rule(11'd4), "del4");
        do_op(1'b0, mk_rule(11'd20), "ins20");

        // Fully occupied table, then free only the last slot.
        for (int i = 0; i < N; i++) mdl[i] = mk_rule(11'(100 + i));
        sync_tbl();
        do_op(1'b0, mk_rule(11'd500), "full");
        do_op(1'b1, mk_rule(11'd600), "notfound");
        do_op(1'b1, mk_rule(11'd129), "del last");
        do_op(1'b0, mk_rule(11'd300), "ins last");
        do_op(1'b0, mk_rule(11'h7FF), "badid ins");
        do_op(1'b1, mk_rule(11'h7FF), "badid del");

        // Reset in the middle of an insert that would write slot 29.
        for (int i = 0; i < N; i++) mdl[i] = (i < N - 1) ? mk_rule(11'(200 + i)) : mk_rule(11'h7FF);
        sync_tbl();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op = 1'b0;
        bus.req_rule = mk_rule(11'd77);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        repeat (19) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst tbl_we", word_t'(tbl_we), word_t'(0));
        check("midrst tbl_addr", word_t'(tbl_addr), word_t'(0));
        check("midrst resp_valid", word_t'(bus.resp_valid), word_t'(0));
        check("midrst ready", word_t'(bus.req_ready), word_t'(0));
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (tbl_we || bus.resp_valid) seen++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst ready after", word_t'(bus.req_ready), word_t'(1));
        repeat (70) begin
            @(negedge clk);
            if (tbl_we || bus.resp_valid) seen++;
        end
        check("midrst silent", word_t'(seen), word_t'(0));
        check_table("midrst");

        // Random mix against the reference model.
        for (int i = 0; i < N; i++)
            mdl[i] = ($urandom_range(0, 1) == 1) ? mk_rule(11'($urandom_range(1, 20)))
                                                 : mk_rule(11'h7FF);
        sync_tbl();
        for (int k = 0; k < 40; k++) begin
            logic [10:0] rid;
            rid = ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom_range(1, 20));
            do_op(1'($urandom_range(0, 1)), mk_rule(rid), $sformatf("rnd%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
